// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs drained onto two CDB channels by round-robin.
// Optional CDB_FLUSH_EN adds the cataclysm input, which flushes queues, rr_ptr and outputs.
module cdb_arbiter #(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ROB_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_SRC-1:0]     src_valid,
  input  logic [NUM_SRC*6-1:0]   src_rob,
  input  logic [NUM_SRC*32-1:0]  src_data,
  output logic [NUM_SRC-1:0]     src_ready,
  output logic                   CDBisCast1,
  output logic [5:0]             CDBrobNum1,
  output logic [31:0]            CDBdata1,
  output logic                   CDBisCast2,
  output logic [5:0]             CDBrobNum2,
  output logic [31:0]            CDBdata2
`ifdef CDB_FLUSH_EN
  ,
  input  logic                   cataclysm
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [5:0]  NO_TAG = 6'(ROB_SIZE);

  logic flush;
`ifdef CDB_FLUSH_EN
  assign flush = cataclysm;
`else
  assign flush = 1'b0;
`endif

  logic [5:0]    q_rob  [NUM_SRC][DEPTH];
  logic [31:0]   q_data [NUM_SRC][DEPTH];
  logic [PW-1:0] head   [NUM_SRC];
  logic [PW-1:0] tail   [NUM_SRC];
  logic [CW-1:0] count  [NUM_SRC];

  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] pop;
  logic [SW-1:0]      rr_ptr;
  logic [SW-1:0]      rr_next;
  logic [SW-1:0]      g1_idx;
  logic [SW-1:0]      g2_idx;
  logic               g1_vld;
  logic               g2_vld;

  function automatic logic [SW-1:0] wrap_idx(input logic [SW-1:0] base, input int unsigned off);
    return SW'((32'(base) + off) % NUM_SRC);
  endfunction

  // Invalid tags complete the handshake but never enter the queue.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    assign src_ready[gi] = (count[gi] != CW'(DEPTH));
    assign push[gi]      = src_valid[gi] & src_ready[gi] & (src_rob[6*gi +: 6] < NO_TAG);
    assign pop[gi]       = (g1_vld && (g1_idx == SW'(gi))) || (g2_vld && (g2_idx == SW'(gi)));
  end

  always_comb begin
    logic [SW-1:0] s;
    s       = '0;
    g1_vld  = 1'b0;
    g2_vld  = 1'b0;
    g1_idx  = '0;
    g2_idx  = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      s = wrap_idx(rr_ptr, k);
      if (count[s] != '0) begin
        if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_idx = s;
        end else if (!g2_vld) begin
          g2_vld = 1'b1;
          g2_idx = s;
        end
      end
    end
    rr_next = rr_ptr;
    if (g2_vld)      rr_next = wrap_idx(g2_idx, 1);
    else if (g1_vld) rr_next = wrap_idx(g1_idx, 1);
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (push[i]) begin
        q_rob[i][tail[i]]  <= src_rob[6*i +: 6];
        q_data[i][tail[i]] <= src_data[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (push[i]) tail[i] <= tail[i] + 1'b1;
        if (pop[i])  head[i] <= head[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr     <= '0;
      CDBisCast1 <= 1'b0;
      CDBrobNum1 <= NO_TAG;
      CDBdata1   <= '0;
      CDBisCast2 <= 1'b0;
      CDBrobNum2 <= NO_TAG;
      CDBdata2   <= '0;
    end else begin
      rr_ptr     <= rr_next;
      CDBisCast1 <= g1_vld;
      CDBrobNum1 <= g1_vld ? q_rob[g1_idx][head[g1_idx]] : NO_TAG;
      CDBdata1   <= g1_vld ? q_data[g1_idx][head[g1_idx]] : '0;
      CDBisCast2 <= g2_vld;
      CDBrobNum2 <= g2_vld ? q_rob[g2_idx][head[g2_idx]] : NO_TAG;
      CDBdata2   <= g2_vld ? q_data[g2_idx][head[g2_idx]] : '0;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model compared every cycle,
// plus directed literal checks. Define CDB_FLUSH_EN to also exercise cataclysm.
module tb_cdb_arbiter;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   src_valid = '0;
  logic [23:0]  src_rob = '0;
  logic [127:0] src_data = '0;
  logic         cataclysm = 1'b0;
  logic [3:0]   src_ready;
  logic         CDBisCast1, CDBisCast2;
  logic [5:0]   CDBrobNum1, CDBrobNum2;
  logic [31:0]  CDBdata1, CDBdata2;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.NUM_SRC(4), .DEPTH(2), .ROB_SIZE(16)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_rob(src_rob), .src_data(src_data),
    .src_ready(src_ready),
    .CDBisCast1(CDBisCast1), .CDBrobNum1(CDBrobNum1), .CDBdata1(CDBdata1),
    .CDBisCast2(CDBisCast2), .CDBrobNum2(CDBrobNum2), .CDBdata2(CDBdata2)
`ifdef CDB_FLUSH_EN
    , .cataclysm(cataclysm)
`endif
  );

  always #5 clk = ~clk;

  logic tb_flush;
`ifdef CDB_FLUSH_EN
  assign tb_flush = cataclysm;
`else
  assign tb_flush = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one FIFO per source, round-robin pointer, expected channel values.
  logic [37:0] mq [4][$];
  int          mrr = 0;
  int          gsel [2];
  int          ng, s;
  logic [3:0]  rdy, exp_rdy;
  logic [37:0] e;
  logic        ev1, ev2;
  logic [5:0]  er1, er2;
  logic [31:0] ed1, ed2;

  always @(posedge clk) begin
    ev1 = 1'b0; er1 = 6'd16; ed1 = '0;
    ev2 = 1'b0; er2 = 6'd16; ed2 = '0;
    if (rst || tb_flush) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      mrr = 0;
    end else begin
      for (int i = 0; i < 4; i++) rdy[i] = (mq[i].size() != DEPTH);
      ng = 0;
      for (int k = 0; k < 4; k++) begin
        s = (mrr + k) % 4;
        if (ng < 2 && mq[s].size() > 0) begin
          gsel[ng] = s;
          ng++;
        end
      end
      if (ng >= 1) begin
        e = mq[gsel[0]].pop_front();
        ev1 = 1'b1; er1 = e[37:32]; ed1 = e[31:0];
      end
      if (ng == 2) begin
        e = mq[gsel[1]].pop_front();
        ev2 = 1'b1; er2 = e[37:32]; ed2 = e[31:0];
      end
      if (ng > 0) mrr = (gsel[ng-1] + 1) % 4;
      for (int i = 0; i < 4; i++)
        if (src_valid[i] && rdy[i] && src_rob[6*i +: 6] < 6'd16)
          mq[i].push_back({src_rob[6*i +: 6], src_data[32*i +: 32]});
    end
    for (int i = 0; i < 4; i++) exp_rdy[i] = (mq[i].size() != DEPTH);
    #1;
    chk("m_cast1", 64'(CDBisCast1), 64'(ev1));
    chk("m_rob1",  64'(CDBrobNum1), 64'(er1));
    chk("m_data1", 64'(CDBdata1),   64'(ed1));
    chk("m_cast2", 64'(CDBisCast2), 64'(ev2));
    chk("m_rob2",  64'(CDBrobNum2), 64'(er2));
    chk("m_data2", 64'(CDBdata2),   64'(ed2));
    chk("m_ready", 64'(src_ready),  64'(exp_rdy));
  end

  task automatic do_reset();
    src_valid = '0;
    cataclysm = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [5:0] rob, input logic [31:0] data);
    src_valid[i]       = 1'b1;
    src_rob[6*i +: 6]  = rob;
    src_data[32*i +: 32] = data;
  endtask

  logic saw_full;
  int   left;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

  initial begin
    // Reset held for two edges
    repeat (2) @(negedge clk);
    chk("rst_cast1", 64'(CDBisCast1), 64'd0);
    chk("rst_rob1",  64'(CDBrobNum1), 64'd16);
    chk("rst_data1", 64'(CDBdata1),   64'd0);
    chk("rst_cast2", 64'(CDBisCast2), 64'd0);
    chk("rst_rob2",  64'(CDBrobNum2), 64'd16);
    chk("rst_ready", 64'(src_ready),  64'hF);
    rst = 1'b0;

    // Single result, one-cycle latency
    set_src(0, 6'd3, 32'hDEADBEEF);
    @(negedge clk);
    src_valid = '0;
    chk("t2_idle_at_accept", 64'(CDBisCast1), 64'd0);
    @(negedge clk);
    chk("t2_cast1", 64'(CDBisCast1), 64'd1);
    chk("t2_rob1",  64'(CDBrobNum1), 64'd3);
    chk("t2_data1", 64'(CDBdata1),   64'hDEADBEEF);
    chk("t2_cast2", 64'(CDBisCast2), 64'd0);
    @(negedge clk);
    chk("t2_idle", 64'(CDBisCast1), 64'd0);

    // All four sources at once: two per cycle in round-robin order
    do_reset();
    for (int i = 0; i < 4; i++) set_src(i, 6'(i + 1), 32'(32'h100 + i));
    @(negedge clk);
    src_valid = '0;
    @(negedge clk);
    chk("t3_a_rob1",  64'(CDBrobNum1), 64'd1);
    chk("t3_a_rob2",  64'(CDBrobNum2), 64'd2);
    chk("t3_a_data2", 64'(CDBdata2),   64'h101);
    @(negedge clk);
    chk("t3_b_rob1", 64'(CDBrobNum1), 64'd3);
    chk("t3_b_rob2", 64'(CDBrobNum2), 64'd4);
    @(negedge clk);
    chk("t3_idle", 64'(CDBisCast1), 64'd0);
    // rr_ptr back at 0: source 0 must win channel 1 over source 3
    set_src(3, 6'd9, 32'h9);
    set_src(0, 6'd8, 32'h8);
    @(negedge clk);
    src_valid = '0;
    @(negedge clk);
    chk("t3_rr_rob1", 64'(CDBrobNum1), 64'd8);
    chk("t3_rr_rob2", 64'(CDBrobNum2), 64'd9);

    // Invalid tag is swallowed, following valid tag goes through
    do_reset();
    set_src(1, 6'd16, 32'h1111);
    @(negedge clk);
    chk("t5_ready_after_bad", 64'(src_ready), 64'hF);
    set_src(1, 6'd5, 32'h55);
    @(negedge clk);
    src_valid = '0;
    chk("t5_no_bcast", 64'(CDBisCast1), 64'd0);
    @(negedge clk);
    chk("t5_cast1", 64'(CDBisCast1), 64'd1);
    chk("t5_rob1",  64'(CDBrobNum1), 64'd5);
    chk("t5_data1", 64'(CDBdata1),   64'h55);
    @(negedge clk);
    chk("t5_idle", 64'(CDBisCast1), 64'd0);

    // Saturation: every source pushes every cycle
    do_reset();
    saw_full = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (src_ready != 4'hF) saw_full = 1'b1;
      for (int i = 0; i < 4; i++) set_src(i, 6'($urandom_range(0, 15)), $urandom);
      @(negedge clk);
    end
    src_valid = '0;
    chk("t4_ready_deasserts", 64'(saw_full), 64'd1);
    left = 20;
    while (left > 0 && (CDBisCast1 || mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() != 0)) begin
      @(negedge clk);
      left--;
    end
    chk("t4_drained",      64'(left > 0), 64'd1);
    chk("t4_drain_ready",  64'(src_ready), 64'hF);

`ifdef CDB_FLUSH_EN
    // Flush with full-ish queues and pushes pending in the flush cycle
    do_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) set_src(i, 6'(c * 4 + i), 32'(c * 16 + i));
      @(negedge clk);
    end
    cataclysm = 1'b1;
    @(negedge clk);
    cataclysm = 1'b0;
    src_valid = '0;
    chk("t6_cast1", 64'(CDBisCast1), 64'd0);
    chk("t6_cast2", 64'(CDBisCast2), 64'd0);
    chk("t6_rob1",  64'(CDBrobNum1), 64'd16);
    chk("t6_ready", 64'(src_ready),  64'hF);
    set_src(0, 6'd7, 32'h77);
    @(negedge clk);
    src_valid = '0;
    chk("t6_empty_after_flush", 64'(CDBisCast1), 64'd0);
    @(negedge clk);
    chk("t6_new_cast1", 64'(CDBisCast1), 64'd1);
    chk("t6_new_rob1",  64'(CDBrobNum1), 64'd7);
    chk("t6_new_cast2", 64'(CDBisCast2), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
